// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - M-stage load/store unit bridging the pipeline to a valid/ready data bus
// One bus transaction per legal access; the pipeline is stalled until the response arrives.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [2:0]  memsizeM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        misalignM,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} stateT;

    stateT       state, stateNext;
    logic        access, sizeBad, alignBad, illegal, startAccess;
    logic [3:0]  stStrb;
    logic [31:0] stData;
    logic [2:0]  sizeQ;
    logic [1:0]  offQ;
    logic [31:0] readQ;
    logic [7:0]  ldByte;
    logic [15:0] ldHalf;
    logic [31:0] ldData;

    always_comb begin
        access      = memreadM | memwriteM;
        sizeBad     = (memsizeM == 3'b011) | (memsizeM == 3'b110) | (memsizeM == 3'b111);
        alignBad    = ((memsizeM[1:0] == 2'b01) & aluoutM[0]) |
                      ((memsizeM[1:0] == 2'b10) & (aluoutM[1:0] != 2'b00));
        illegal     = access & (sizeBad | alignBad);
        startAccess = access & ~illegal;
    end

    // Stores replicate the datum across lanes so the strobe alone selects the bytes.
    always_comb begin
        stStrb = 4'b0000;
        stData = writedataM;
        if (memwriteM) begin
            case (memsizeM[1:0])
                2'b00: begin
                    stStrb = 4'b0001 << aluoutM[1:0];
                    stData = {4{writedataM[7:0]}};
                end
                2'b01: begin
                    stStrb = 4'b0011 << {aluoutM[1], 1'b0};
                    stData = {2{writedataM[15:0]}};
                end
                default: stStrb = 4'b1111;
            endcase
        end
    end

    always_comb begin
        ldByte = bus_rdata[{offQ, 3'b000} +: 8];
        ldHalf = offQ[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (sizeQ)
            3'b000:  ldData = {{24{ldByte[7]}}, ldByte};
            3'b001:  ldData = {{16{ldHalf[15]}}, ldHalf};
            3'b100:  ldData = {24'h000000, ldByte};
            3'b101:  ldData = {16'h0000, ldHalf};
            default: ldData = bus_rdata;
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (startAccess) stateNext = REQ;
            REQ:     if (bus_ready)   stateNext = RESP;
            RESP:    if (bus_rvalid)  stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus_valid = ~reset & (state == REQ);
        stallM    = ~reset & (((state == IDLE) & startAccess) | (state == REQ) | (state == RESP));
        misalignM = ~reset & (state == IDLE) & illegal;
        readdataM = misalignM ? 32'h0 : readQ;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_wstrb <= 4'b0000;
            sizeQ     <= 3'b000;
            offQ      <= 2'b00;
            readQ     <= 32'h0;
        end else begin
            state <= stateNext;
            // Bus outputs are frozen here so they stay stable for the whole REQ phase.
            if (state == IDLE && startAccess) begin
                bus_we    <= memwriteM;
                bus_addr  <= {aluoutM[31:2], 2'b00};
                bus_wdata <= stData;
                bus_wstrb <= stStrb;
                sizeQ     <= memsizeM;
                offQ      <= aluoutM[1:0];
            end
            if (state == RESP && bus_rvalid && !bus_we) begin
                readQ <= ldData;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized bench for mem_stage_lsu against a transaction-level model
module tb_mem_stage_lsu;

    logic        clk;
    logic        reset;
    logic        memreadM, memwriteM;
    logic [2:0]  memsizeM;
    logic [31:0] aluoutM, writedataM;
    logic [31:0] readdataM;
    logic        stallM, misalignM;
    logic        bus_valid, bus_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    mem_stage_lsu dut (
        .clk        (clk),
        .reset      (reset),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .memsizeM   (memsizeM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .misalignM  (misalignM),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nPass = 0;
    int nTotal = 0;
    int stallCnt = 0;
    bit chk = 0;

    logic        eStall, eMis, eValid, busChk, wdChk, eWe;
    logic [31:0] eAddr, eWdata, eRd;
    logic [3:0]  eWstrb;
    logic [31:0] lastRd = 32'h0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit legalM(input logic [2:0] sz, input logic [31:0] a);
        case (sz)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (a % 2) == 0;
            3'd2:       return (a % 4) == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] strobeM(input logic [2:0] sz, input logic [31:0] a);
        int off = int'(a % 4);
        case (sz % 4)
            0:       return 4'(1 << off);
            1:       return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] wdataM(input logic [2:0] sz, input logic [31:0] wd);
        case (sz % 4)
            0:       return (wd & 32'hFF) * 32'h01010101;
            1:       return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] loadM(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] sh, b, h;
        sh = w >> (8 * (a % 4));
        b  = sh & 32'hFF;
        h  = sh & 32'hFFFF;
        case (sz)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic step();
        #2;
        if (stallM === 1'b1) stallCnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        bus_ready  = 1'($urandom % 2);
        bus_rvalid = 1'($urandom % 2);
        bus_rdata  = $urandom;
    endtask

    always @(negedge clk) begin
        if (chk) begin
            check("stallM", 32'(stallM), 32'(eStall));
            check("misalignM", 32'(misalignM), 32'(eMis));
            check("bus_valid", 32'(bus_valid), 32'(eValid));
            check("readdataM", readdataM, eRd);
            if (busChk) begin
                check("bus_we", 32'(bus_we), 32'(eWe));
                check("bus_addr", bus_addr, eAddr);
                check("bus_wstrb", 32'(bus_wstrb), 32'(eWstrb));
                if (wdChk) check("bus_wdata", bus_wdata, eWdata);
            end
        end
    end

    task automatic doInstr(input logic rd, input logic wr, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rdat, input int reqN, input int respN,
                           input bit useLit, input logic [31:0] litAddr, input logic [3:0] litSt,
                           input logic [31:0] litWd, input logic [31:0] litRd, input int litStall);
        bit acc, legal;
        acc   = rd | wr;
        legal = acc && legalM(sz, a);
        memreadM = rd; memwriteM = wr; memsizeM = sz; aluoutM = a; writedataM = wd;
        stallCnt = 0; busChk = 0; wdChk = 0; eValid = 0; eMis = 0;
        if (!legal) begin
            eStall = 0; eMis = acc; eRd = acc ? 32'h0 : lastRd;
            noise();
            if (useLit) begin
                #1;
                check("lit_illegal_readdata", readdataM, litRd);
            end
            step();
        end else begin
            eStall = 1; eRd = lastRd;
            noise();
            step();
            eValid = 1; busChk = 1; wdChk = wr; eWe = wr;
            eAddr = a - (a % 4);
            eWstrb = wr ? strobeM(sz, a) : 4'b0000;
            eWdata = wdataM(sz, wd);
            for (int i = 0; i < reqN; i++) begin
                noise();
                bus_ready = (i == reqN - 1);
                if (useLit && i == 0) begin
                    #1;
                    check("lit_bus_addr", bus_addr, litAddr);
                    check("lit_bus_wstrb", 32'(bus_wstrb), 32'(litSt));
                    if (wr) check("lit_bus_wdata", bus_wdata, litWd);
                end
                step();
            end
            eValid = 0; busChk = 0; wdChk = 0;
            for (int i = 0; i < respN; i++) begin
                noise();
                bus_rvalid = (i == respN - 1);
                if (i == respN - 1) bus_rdata = rdat;
                step();
            end
            if (!wr) lastRd = loadM(sz, a, rdat);
            eStall = 0; eRd = lastRd;
            noise();
            if (useLit && !wr) begin
                #1;
                check("lit_readdata", readdataM, litRd);
            end
            step();
        end
        if (useLit) check("lit_stall_cycles", 32'(stallCnt), 32'(litStall));
    endtask

    initial begin
        reset = 1; memreadM = 1; memwriteM = 0; memsizeM = 3'b011; aluoutM = 32'h0;
        writedataM = 32'h0; bus_ready = 0; bus_rvalid = 0; bus_rdata = 32'h0;
        @(posedge clk);
        #1;
        eStall = 0; eMis = 0; eValid = 0; eRd = 32'h0;
        busChk = 1; wdChk = 1; eWe = 0; eAddr = 32'h0; eWstrb = 4'b0000; eWdata = 32'h0;
        chk = 1;
        step();
        step();
        reset = 0;
        busChk = 0; wdChk = 0;

        doInstr(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 1, 1, 1, 32'h100, 4'b0000, 0, 32'hDEADBEEF, 3);
        doInstr(1, 0, 3'b000, 32'h103, 0, 32'h80123456, 1, 1, 1, 32'h100, 4'b0000, 0, 32'hFFFFFF80, 3);
        doInstr(1, 0, 3'b100, 32'h103, 0, 32'h80123456, 1, 1, 1, 32'h100, 4'b0000, 0, 32'h00000080, 3);
        doInstr(1, 0, 3'b101, 32'h102, 0, 32'h80123456, 1, 1, 1, 32'h100, 4'b0000, 0, 32'h00008012, 3);
        doInstr(0, 1, 3'b000, 32'h201, 32'hA5, 0, 1, 1, 1, 32'h200, 4'b0010, 32'hA5A5A5A5, 0, 3);
        doInstr(0, 1, 3'b001, 32'h202, 32'h1234, 0, 1, 1, 1, 32'h200, 4'b1100, 32'h12341234, 0, 3);
        doInstr(1, 0, 3'b010, 32'h400, 0, 32'hCAFEF00D, 4, 2, 1, 32'h400, 4'b0000, 0, 32'hCAFEF00D, 7);
        doInstr(1, 0, 3'b010, 32'h102, 0, 0, 1, 1, 1, 0, 0, 0, 32'h0, 0);
        doInstr(1, 0, 3'b001, 32'h001, 0, 0, 1, 1, 1, 0, 0, 0, 32'h0, 0);
        doInstr(1, 0, 3'b011, 32'h000, 0, 0, 1, 1, 1, 0, 0, 0, 32'h0, 0);

        // reset arrives while the response is outstanding; the late rvalid must be dropped
        memreadM = 1; memwriteM = 0; memsizeM = 3'b010; aluoutM = 32'h300;
        bus_ready = 0; bus_rvalid = 0;
        eStall = 1; eMis = 0; eValid = 0; busChk = 0; wdChk = 0; eRd = lastRd;
        step();
        bus_ready = 1; eValid = 1; busChk = 1; eWe = 0; eAddr = 32'h300; eWstrb = 4'b0000;
        step();
        reset = 1; bus_ready = 0; bus_rvalid = 0; busChk = 0; eValid = 0; eStall = 0;
        step();
        reset = 0; memreadM = 0; bus_rvalid = 1; bus_rdata = 32'h55AA55AA;
        lastRd = 32'h0; eRd = 32'h0;
        busChk = 1; wdChk = 1; eWe = 0; eAddr = 32'h0; eWstrb = 4'b0000; eWdata = 32'h0;
        step();
        step();
        busChk = 0; wdChk = 0;
        doInstr(1, 0, 3'b010, 32'h304, 0, 32'h0BADF00D, 1, 1, 1, 32'h304, 4'b0000, 0, 32'h0BADF00D, 3);

        for (int n = 0; n < 300; n++) begin
            int k;
            logic rd, wr;
            logic [2:0] sz;
            logic [31:0] a;
            k  = int'($urandom % 8);
            rd = (k >= 1 && k <= 3) || k == 7;
            wr = (k >= 4);
            if ($urandom % 4 != 0) begin
                case ($urandom % 5)
                    0: sz = 3'd0;
                    1: sz = 3'd1;
                    2: sz = 3'd2;
                    3: sz = 3'd4;
                    default: sz = 3'd5;
                endcase
            end else begin
                sz = 3'($urandom % 8);
            end
            a = $urandom;
            if ($urandom % 2 == 0) a[1:0] = 2'b00;
            doInstr(rd, wr, sz, a, $urandom, $urandom,
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 0, 0, 0, 0, 0, 0);
        end

        chk = 0;
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
